// File: rtl/pipeline_memwb_stage.sv
// pipeline_memwb_stage
//   Memory/writeback pipeline stage. Holds one entry (control word, ALU result,
//   store data) between execute and writeback, with valid/ready handshakes on
//   both sides and a variable-latency data-memory request/acknowledge port.
//   Also holds the N/Z/V (and optional C) status flags, which are updated only
//   when an entry with control[LOADS_BIT]=1 is accepted.
//
// Build option:
//   PIPELINE_MEMWB_CARRY_EN  when defined, a C flag register captures carry_in;
//                            otherwise C_out is tied low and carry_in is unused.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        upstream handshake
//   control_in, result_in,   entry payload (result doubles as memory address)
//   data_Rd_in
//   highbit_data_Rn_in,      flag inputs (operand MSBs, ALU carry)
//   highbit_shifted_Rm_in,
//   carry_in
//   out_valid/out_ready      downstream (writeback) handshake
//   control_out, result_out  held entry; result_out carries load data for LDR
//   N_out, Z_out, V_out,     status flags
//   C_out
//   mem_req, mem_write,      data-memory request (stable until mem_ack)
//   addr_mem, wdata_mem
//   mem_rdata, mem_ack       data-memory response
module pipeline_memwb_stage #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 9,
    parameter int CTRL_W    = 22,
    parameter int OPC_LSB   = 19,
    parameter int LOADS_BIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] control_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] data_Rd_in,
    input  logic              highbit_data_Rn_in,
    input  logic              highbit_shifted_Rm_in,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] control_out,
    output logic [DATA_W-1:0] result_out,
    output logic              N_out,
    output logic              Z_out,
    output logic              V_out,
    output logic              C_out,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] wdata_mem,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {S_EMPTY, S_MEM, S_FULL} state_t;

    localparam logic [2:0] OPC_STR = 3'b100;
    localparam logic [2:0] OPC_LDR = 3'b011;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    // Zero flag is stored inverted so an all-zero flag register reads Z=1.
    logic              n_q, nz_q, v_q;

    logic [2:0] in_opc, held_opc;
    logic       in_is_mem, take, flag_we;

    assign in_opc    = control_in[OPC_LSB+2:OPC_LSB];
    assign held_opc  = ctrl_q[OPC_LSB+2:OPC_LSB];
    assign in_is_mem = (in_opc == OPC_STR) || (in_opc == OPC_LDR);

    // Only FULL makes in_ready depend on a live input (out_ready).
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_EMPTY: in_ready = 1'b1;
            S_FULL:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign take    = in_valid && in_ready;
    assign flag_we = take && control_in[LOADS_BIT];

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        rd_d     = rd_q;
        case (state_q)
            S_EMPTY: ;
            S_MEM: begin
                if (mem_ack) begin
                    if (held_opc == OPC_LDR) result_d = mem_rdata;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (out_ready && !in_valid) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
        // A new entry replaces the held one on the handoff edge, so FULL can
        // hand off and reload in the same cycle without a bubble.
        if (take) begin
            ctrl_d   = control_in;
            result_d = result_in;
            rd_d     = data_Rd_in;
            state_d  = in_is_mem ? S_MEM : S_FULL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            ctrl_q   <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    // Flags come from the ALU-side inputs at acceptance, never from load data.
    logic v_calc;
    assign v_calc = ({highbit_data_Rn_in, highbit_shifted_Rm_in, result_in[DATA_W-1]} == 3'b011) ||
                    ({highbit_data_Rn_in, highbit_shifted_Rm_in, result_in[DATA_W-1]} == 3'b100);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q  <= 1'b0;
            nz_q <= 1'b0;
            v_q  <= 1'b0;
        end else if (flag_we) begin
            n_q  <= result_in[DATA_W-1];
            nz_q <= (result_in != '0);
            v_q  <= v_calc;
        end
    end

`ifdef PIPELINE_MEMWB_CARRY_EN
    logic c_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          c_q <= 1'b0;
        else if (flag_we) c_q <= carry_in;
    end
    assign C_out = c_q;
`else
    logic unused_carry;
    assign unused_carry = carry_in;
    assign C_out        = 1'b0;
`endif

    assign N_out = n_q;
    assign Z_out = !nz_q;
    assign V_out = v_q;

    assign out_valid   = (state_q == S_FULL);
    assign control_out = ctrl_q;
    assign result_out  = result_q;

    assign mem_req   = (state_q == S_MEM);
    assign mem_write = mem_req && (held_opc == OPC_STR);
    assign addr_mem  = result_q[ADDR_W-1:0];
    assign wdata_mem = rd_q;

endmodule

// File: tb/tb_pipeline_memwb_stage.sv
module tb_pipeline_memwb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [21:0] control_in;
    logic [15:0] result_in, data_Rd_in;
    logic        highbit_data_Rn_in, highbit_shifted_Rm_in, carry_in;
    logic        out_valid, out_ready;
    logic [21:0] control_out;
    logic [15:0] result_out;
    logic        N_out, Z_out, V_out, C_out;
    logic        mem_req, mem_write;
    logic [8:0]  addr_mem;
    logic [15:0] wdata_mem, mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

`ifdef PIPELINE_MEMWB_CARRY_EN
    localparam logic C_EN = 1'b1;
`else
    localparam logic C_EN = 1'b0;
`endif

    pipeline_memwb_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .control_in(control_in), .result_in(result_in), .data_Rd_in(data_Rd_in),
        .highbit_data_Rn_in(highbit_data_Rn_in), .highbit_shifted_Rm_in(highbit_shifted_Rm_in),
        .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .control_out(control_out), .result_out(result_out),
        .N_out(N_out), .Z_out(Z_out), .V_out(V_out), .C_out(C_out),
        .mem_req(mem_req), .mem_write(mem_write), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] mk(input logic [2:0] opc, input logic ld, input logic [7:0] tag);
        logic [21:0] c;
        c = '0;
        c[21:19] = opc;
        c[8] = ld;
        c[7:0] = tag;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [21:0] c, input logic [15:0] r, input logic [15:0] d,
                         input logic rn, input logic rm, input logic cy);
        in_valid = 1'b1; control_in = c; result_in = r; data_Rd_in = d;
        highbit_data_Rn_in = rn; highbit_shifted_Rm_in = rm; carry_in = cy;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        control_in = '0; result_in = '0; data_Rd_in = '0;
        highbit_data_Rn_in = 1'b0; highbit_shifted_Rm_in = 1'b0; carry_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
        checks++; if ({N_out, Z_out, V_out, C_out} !== 4'b0100) begin errors++; $display("FAIL rst_flags got=%b exp=0100", {N_out, Z_out, V_out, C_out}); end
        checks++; if (result_out !== 16'h0 || control_out !== 22'h0) begin errors++; $display("FAIL rst_regs got=%h/%h exp=0/0", result_out, control_out); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] res [3];
        res[0] = 16'h0011; res[1] = 16'h0022; res[2] = 16'h0033;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(mk(3'b000, 1'b0, 8'(i + 1)), res[i], 16'h0, 1'b0, 1'b0, 1'b0);
            tick();
            checks++; if (out_valid !== 1'b1 || result_out !== res[i]) begin errors++; $display("FAIL b2b_%0d got v=%0h r=%h exp v=1 r=%h", i, out_valid, result_out, res[i]); end
            checks++; if (control_out[7:0] !== 8'(i + 1) || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ctl_%0d got tag=%h rdy=%0h exp tag=%h rdy=1", i, control_out[7:0], in_ready, 8'(i + 1)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0h exp=0", out_valid); end
        checks++; if (Z_out !== 1'b1) begin errors++; $display("FAIL b2b_flags_held got Z=%0h exp=1", Z_out); end
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        drive(mk(3'b000, 1'b1, 8'hA1), 16'h8000, 16'h0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if ({N_out, Z_out, V_out, C_out} !== {3'b101, C_EN}) begin errors++; $display("FAIL flags_set got=%b exp=%b", {N_out, Z_out, V_out, C_out}, {3'b101, C_EN}); end
        drive(mk(3'b000, 1'b0, 8'hA2), 16'h0000, 16'h0, 1'b1, 1'b1, 1'b0);
        tick();
        checks++; if ({N_out, Z_out, V_out, C_out} !== {3'b101, C_EN}) begin errors++; $display("FAIL flags_hold got=%b exp=%b", {N_out, Z_out, V_out, C_out}, {3'b101, C_EN}); end
        drive(mk(3'b000, 1'b1, 8'hA3), 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if ({N_out, Z_out, V_out, C_out} !== 4'b0100) begin errors++; $display("FAIL flags_zero got=%b exp=0100", {N_out, Z_out, V_out, C_out}); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_ldr_wait();
        out_ready = 1'b0;
        drive(mk(3'b011, 1'b0, 8'hB1), 16'h0105, 16'h0, 1'b1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req !== 1'b1 || mem_write !== 1'b0 || addr_mem !== 9'h105) begin errors++; $display("FAIL ldr_wait_%0d got req=%0h wr=%0h addr=%h exp req=1 wr=0 addr=105", i, mem_req, mem_write, addr_mem); end
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL ldr_wait_hs_%0d got ov=%0h ir=%0h exp 0/0", i, out_valid, in_ready); end
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        checks++; if (out_valid !== 1'b1 || result_out !== 16'hBEEF || mem_req !== 1'b0) begin errors++; $display("FAIL ldr_done got ov=%0h r=%h req=%0h exp ov=1 r=beef req=0", out_valid, result_out, mem_req); end
        checks++; if ({N_out, Z_out, V_out, C_out} !== 4'b0100) begin errors++; $display("FAIL ldr_flags got=%b exp=0100", {N_out, Z_out, V_out, C_out}); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_str_and_backpressure();
        out_ready = 1'b0;
        drive(mk(3'b100, 1'b0, 8'hC1), 16'h0042, 16'h1234, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_write !== 1'b1 || addr_mem !== 9'h042 || wdata_mem !== 16'h1234) begin errors++; $display("FAIL str_req got req=%0h wr=%0h addr=%h wd=%h exp 1/1/042/1234", mem_req, mem_write, addr_mem, wdata_mem); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || result_out !== 16'h0042) begin errors++; $display("FAIL str_done got req=%0h ov=%0h r=%h exp 0/1/0042", mem_req, out_valid, result_out); end
        drive(mk(3'b000, 1'b0, 8'h77), 16'h0777, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || result_out !== 16'h0042 || control_out[7:0] !== 8'hC1) begin errors++; $display("FAIL bp_hold_%0d got ir=%0h ov=%0h r=%h tag=%h exp 0/1/0042/c1", i, in_ready, out_valid, result_out, control_out[7:0]); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0h exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result_out !== 16'h0777 || control_out[7:0] !== 8'h77) begin errors++; $display("FAIL bp_handoff got ov=%0h r=%h tag=%h exp 1/0777/77", out_valid, result_out, control_out[7:0]); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0h exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_mem();
        out_ready = 1'b1;
        drive(mk(3'b000, 1'b1, 8'hD0), 16'h8000, 16'h0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(mk(3'b011, 1'b0, 8'hD1), 16'h0100, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_req got=%0h exp=1", mem_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_hs got req=%0h ov=%0h ir=%0h exp 0/0/1", mem_req, out_valid, in_ready); end
        checks++; if ({N_out, Z_out, V_out, C_out} !== 4'b0100) begin errors++; $display("FAIL mid_rst_flags got=%b exp=0100", {N_out, Z_out, V_out, C_out}); end
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || mem_req !== 1'b0 || result_out !== 16'h0) begin errors++; $display("FAIL late_ack got ov=%0h req=%0h r=%h exp 0/0/0", out_valid, mem_req, result_out); end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_flags();
        test_ldr_wait();
        test_str_and_backpressure();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
